// File: rtl/prom_loader_pkg.sv
// prom_loader_pkg
//   Shared definitions for the UART-to-PROM boot loader:
//   - state_t      : loader FSM state encoding
//   - SYNC_DEFAULT : default frame start marker
//   - CSUM_W       : width of the running frame checksum
//   - is_busy()    : true while a frame is being parsed
package prom_loader_pkg;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_LEN   = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         CSUM_W       = 8;

    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN) || (s == ST_LO) || (s == ST_HI) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/prom_loader_timer.sv
// prom_loader_timer
//   Inter-byte idle timeout counter.
//   Ports:
//     clk, reset : clock, async active-high reset
//     clr        : restart the count (a byte arrived)
//     en         : count while high; count is held at zero otherwise
//     expire     : one-cycle pulse when TICKS idle cycles have elapsed
module prom_loader_timer #(
    parameter int TICKS = 6250
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

    logic [CW-1:0] cnt;

    // A byte in the same cycle as the terminal count wins over the timeout.
    assign expire = en && !clr && (cnt == CW'(TICKS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr || !en || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prom_loader.sv
// prom_loader
//   Framed UART-to-PROM boot controller. Parses
//     SYNC, L, {lo, hi} x L, [C]
//   writes each 16-bit word into the instruction PROM and releases the
//   CPU reset only once a complete program has been written.
//   Optional feature macro: PROM_LOADER_CHECKSUM_EN
//     defined   : frame carries a trailing checksum byte C, accepted when
//                 (L + sum(payload) + C) mod 256 == 0
//     undefined : frame ends after the last payload byte, no checksum
//   Ports:
//     clk, reset   : clock, async active-high reset
//     rx_data_i    : received byte
//     rx_ready_i   : byte strobe (one cycle per byte)
//     rx_ack_o     : combinational copy of rx_ready_i
//     prom_addr_o  : PROM write address
//     prom_data_o  : PROM write data {hi, lo}
//     prom_we_o    : PROM write enable pulse
//     cpu_reset_o  : CPU held in reset unless a program is loaded
//     busy_o       : frame in progress
//     done_o       : verified program loaded
//     error_o      : last frame failed (sticky until next sync byte)
module prom_loader
    import prom_loader_pkg::*;
#(
    parameter int          ROM_WORDS     = 38,
    parameter int          TIMEOUT_TICKS = 6250,
    parameter logic [7:0]  SYNC_BYTE     = SYNC_DEFAULT,
    localparam int         AW            = (ROM_WORDS > 1) ? $clog2(ROM_WORDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_ready_i,
    output logic          rx_ack_o,
    output logic [AW-1:0] prom_addr_o,
    output logic [15:0]   prom_data_o,
    output logic          prom_we_o,
    output logic          cpu_reset_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o
);

    state_t        state, nxt;
    logic [7:0]    len;
    logic [AW-1:0] idx;
    logic [7:0]    lo;
    logic          is_sync, len_bad, last;
    logic          set_err, clr_err, wr, expire;
`ifdef PROM_LOADER_CHECKSUM_EN
    logic [CSUM_W-1:0] sum;
    logic [CSUM_W-1:0] sum_total;
    assign sum_total = sum + rx_data_i;
`endif

    assign rx_ack_o = rx_ready_i;
    assign is_sync  = (rx_data_i == SYNC_BYTE);
    assign len_bad  = (rx_data_i == 8'd0) || (int'(rx_data_i) > ROM_WORDS);
    assign last     = (8'(idx) == (len - 8'd1));

    prom_loader_timer #(
        .TICKS (TIMEOUT_TICKS)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr    (rx_ready_i),
        .en     (busy_o),
        .expire (expire)
    );

    always_comb begin
        nxt     = state;
        set_err = 1'b0;
        clr_err = 1'b0;
        wr      = 1'b0;
        case (state)
            ST_HUNT: if (rx_ready_i && is_sync) begin
                nxt     = ST_LEN;
                clr_err = 1'b1;
            end
            ST_LEN: if (rx_ready_i) begin
                if (len_bad) begin
                    nxt     = ST_HUNT;
                    set_err = 1'b1;
                end else begin
                    nxt = ST_LO;
                end
            end
            ST_LO: if (rx_ready_i) nxt = ST_HI;
            ST_HI: if (rx_ready_i) begin
                wr = 1'b1;
                if (last) begin
`ifdef PROM_LOADER_CHECKSUM_EN
                    nxt = ST_CHECK;
`else
                    nxt = ST_DONE;
`endif
                end else begin
                    nxt = ST_LO;
                end
            end
`ifdef PROM_LOADER_CHECKSUM_EN
            ST_CHECK: if (rx_ready_i) begin
                if (sum_total == '0) begin
                    nxt = ST_DONE;
                end else begin
                    nxt     = ST_HUNT;
                    set_err = 1'b1;
                end
            end
`endif
            ST_DONE: if (rx_ready_i && is_sync) begin
                nxt     = ST_LEN;
                clr_err = 1'b1;
            end
            default: nxt = ST_HUNT;
        endcase
        // expire never coincides with a strobe, so it cannot collide with wr.
        if (expire) begin
            nxt     = ST_HUNT;
            set_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_HUNT;
            len         <= '0;
            idx         <= '0;
            lo          <= '0;
            prom_addr_o <= '0;
            prom_data_o <= '0;
            prom_we_o   <= 1'b0;
            cpu_reset_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            state       <= nxt;
            // Status outputs are decoded from the next state so they line up
            // with the state register rather than lagging it by a cycle.
            busy_o      <= is_busy(nxt);
            done_o      <= (nxt == ST_DONE);
            cpu_reset_o <= (nxt != ST_DONE);
            if (set_err)      error_o <= 1'b1;
            else if (clr_err) error_o <= 1'b0;

            prom_we_o <= wr;
            if (wr) begin
                prom_addr_o <= idx;
                prom_data_o <= {rx_data_i, lo};
            end

            if (state == ST_LEN && rx_ready_i && !len_bad) begin
                len <= rx_data_i;
                idx <= '0;
            end
            if (state == ST_LO && rx_ready_i) lo <= rx_data_i;
            if (state == ST_HI && rx_ready_i && !last) idx <= idx + 1'b1;
        end
    end

`ifdef PROM_LOADER_CHECKSUM_EN
    // Running checksum: seeded with L, accumulates every payload byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (rx_ready_i) begin
            if (state == ST_LEN)                      sum <= rx_data_i;
            else if (state == ST_LO || state == ST_HI) sum <= sum_total;
        end
    end
`endif

endmodule

// File: tb/tb_prom_loader.sv
// tb_prom_loader
//   Directed-vector bench for prom_loader. Expectations adapt to whether
//   PROM_LOADER_CHECKSUM_EN is defined for the build.
module tb_prom_loader;

    localparam int TT = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_ack;
    logic [5:0]  prom_addr;
    logic [15:0] prom_data;
    logic        prom_we;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int errs   = 0;
    int checks = 0;

    int          wr_cnt = 0;
    logic [5:0]  last_addr;
    logic [15:0] mem [0:63];
    logic [7:0]  q [$];

    prom_loader #(
        .ROM_WORDS     (38),
        .TIMEOUT_TICKS (TT),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data_i   (rx_data),
        .rx_ready_i  (rx_ready),
        .rx_ack_o    (rx_ack),
        .prom_addr_o (prom_addr),
        .prom_data_o (prom_data),
        .prom_we_o   (prom_we),
        .cpu_reset_o (cpu_reset),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    // Capture every PROM write seen on the bus.
    always @(negedge clk) begin
        if (prom_we) begin
            mem[prom_addr] = prom_data;
            last_addr      = prom_addr;
            wr_cnt         = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        #1;
    endtask

    // Sends the queue with one idle cycle between bytes, or back to back.
    task automatic send_q(input bit b2b);
        foreach (q[i]) begin
            if (b2b) begin
                @(negedge clk);
                rx_data  = q[i];
                rx_ready = 1'b1;
            end else begin
                send_byte(q[i]);
            end
        end
        if (b2b) begin
            @(negedge clk);
            rx_ready = 1'b0;
            #1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic [7:0] csum;

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        idle(3);

        // ---- reset state ----
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_we",        prom_we,   0);
        chk("rst_addr",      prom_addr, 0);
        chk("rst_data",      prom_data, 0);
        chk("rst_busy",      busy,      0);
        chk("rst_done",      done,      0);
        chk("rst_error",     error,     0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        rx_ready = 1'b1;
        #1;
        chk("ack_hi", rx_ack, 1);
        rx_ready = 1'b0;
        #1;
        chk("ack_lo", rx_ack, 0);

        // ---- noise before sync, then the good frame ----
        wr_cnt = 0;
        q = '{8'h00, 8'hFF, 8'h5A};
        send_q(0);
        chk("noise_busy", busy, 0);
        chk("noise_err",  error, 0);
        send_byte(8'hA5);
        chk("sync_busy", busy, 1);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h12);
        chk("w0_we",   prom_we,   1);
        chk("w0_addr", prom_addr, 0);
        chk("w0_data", prom_data, 16'h1234);
        idle(1);
        chk("w0_pulse", prom_we, 0);
        send_byte(8'h78);
        send_byte(8'h56);
        chk("w1_addr", prom_addr, 1);
        chk("w1_data", prom_data, 16'h5678);
`ifdef PROM_LOADER_CHECKSUM_EN
        chk("pre_c_done", done,      0);
        chk("pre_c_cpu",  cpu_reset, 1);
        send_byte(8'hEA);
`endif
        chk("good_done", done,      1);
        chk("good_cpu",  cpu_reset, 0);
        chk("good_busy", busy,      0);
        chk("good_err",  error,     0);
`ifndef PROM_LOADER_CHECKSUM_EN
        send_byte(8'hEA);
        chk("good_done_hold", done, 1);
`endif
        chk("good_wr_cnt", wr_cnt, 2);
        chk("good_mem0",   mem[0], 16'h1234);
        chk("good_mem1",   mem[1], 16'h5678);

        // ---- bad checksum, then a valid frame clears the error ----
        wr_cnt = 0;
        q = '{8'hA5, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEB};
        send_q(0);
        chk("bad_wr_cnt", wr_cnt, 2);
`ifdef PROM_LOADER_CHECKSUM_EN
        chk("bad_err",  error,     1);
        chk("bad_done", done,      0);
        chk("bad_cpu",  cpu_reset, 1);
`else
        chk("bad_err",  error,     0);
        chk("bad_done", done,      1);
`endif
        send_byte(8'hA5);
        chk("resync_err",  error,     0);
        chk("resync_busy", busy,      1);
        chk("resync_done", done,      0);
        chk("resync_cpu",  cpu_reset, 1);
        q = '{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA};
        send_q(0);
        chk("refill_done", done,  1);
        chk("refill_err",  error, 0);

        // ---- length bounds ----
        wr_cnt = 0;
        send_byte(8'hA5);
        send_byte(8'h27);
        idle(2);
        chk("len39_err",  error,  1);
        chk("len39_busy", busy,   0);
        chk("len39_wr",   wr_cnt, 0);
        q = '{8'hA5, 8'h26};
        csum = 8'h26;
        for (int i = 0; i < 38; i++) begin
            q.push_back(8'(i));
            q.push_back(8'(8'h40 + i));
            csum = csum + 8'(i) + 8'(8'h40 + i);
        end
        q.push_back(8'(0) - csum);
        send_q(0);
        chk("len38_wr_cnt", wr_cnt,    38);
        chk("len38_last",   last_addr, 37);
        chk("len38_mem0",   mem[0],    16'h4000);
        chk("len38_mem19",  mem[19],   16'h5313);
        chk("len38_mem37",  mem[37],   16'h6525);
        chk("len38_done",   done,      1);
        chk("len38_err",    error,     0);

        // ---- timeout ----
        wr_cnt = 0;
        q = '{8'hA5, 8'h01, 8'h34};
        send_q(0);
        repeat (TT - 1) @(negedge clk);
        #1;
        chk("to_pre_err",  error, 0);
        chk("to_pre_busy", busy,  1);
        @(negedge clk);
        #1;
        chk("to_err",  error,     1);
        chk("to_busy", busy,      0);
        chk("to_cpu",  cpu_reset, 1);
        chk("to_wr",   wr_cnt,    0);

        // ---- async reset between LO and HI of word 3 ----
        wr_cnt = 0;
        q = '{8'hA5, 8'h05, 8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13};
        send_q(0);
        chk("pre_rst_wr",   wr_cnt, 3);
        chk("pre_rst_busy", busy,   1);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_busy", busy,      0);
        chk("arst_cpu",  cpu_reset, 1);
        chk("arst_addr", prom_addr, 0);
        chk("arst_data", prom_data, 0);
        chk("arst_err",  error,     0);
        idle(2);
        reset = 1'b0;
        send_byte(8'h23);
        idle(3);
        chk("arst_no_wr", wr_cnt, 3);
        chk("arst_hunt",  busy,   0);

        // ---- back-to-back stream ----
        wr_cnt = 0;
        q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h98};
        send_q(1);
        chk("b2b_wr_cnt", wr_cnt, 3);
        chk("b2b_mem0",   mem[0], 16'h2211);
        chk("b2b_mem1",   mem[1], 16'h4433);
        chk("b2b_mem2",   mem[2], 16'h6655);
        chk("b2b_done",   done,   1);
        chk("b2b_err",    error,  0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/prom_loader.md
# prom_loader

Framed UART-to-PROM boot controller for the CPU subsystem. It consumes received bytes from the UART and parses a sync/length/payload/checksum frame. Payload words are written into the instruction PROM through a single write port. The CPU is held in reset until a complete, verified program has been written.

## Interface
Parameters:
- `ROM_WORDS`, 38: PROM depth in 16-bit words; `AW = $clog2(ROM_WORDS)`.
- `TIMEOUT_TICKS`, 6250: idle cycles allowed between bytes inside a frame (1 s at 6250 Hz).
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `rx_data_i` in 8: received byte.
- `rx_ready_i` in 1: byte-valid strobe, one cycle per byte.
- `rx_ack_o` out 1: combinationally equal to `rx_ready_i`; every byte is consumed.
- `prom_addr_o` out AW: PROM write address.
- `prom_data_o` out 16: PROM write data, `{high byte, low byte}`.
- `prom_we_o` out 1: PROM write enable, one-cycle pulse.
- `cpu_reset_o` out 1: CPU reset request.
- `busy_o` out 1: a frame is in progress.
- `done_o` out 1: a verified program is loaded.
- `error_o` out 1: the last frame failed; sticky until the next sync byte.

## Operation
- Frame format: `SYNC_BYTE`, L (word count), then 2·L payload bytes, low byte first, then checksum C.
  - A frame is valid when `(L + Σ payload bytes + C) mod 256 == 0`.
- States: HUNT, LEN, LO, HI, CHECK, DONE. All transitions happen on `rx_ready_i` only, except the timeout.
- HUNT: a byte equal to `SYNC_BYTE` moves to LEN and clears `error_o`. Any other byte is ignored.
- LEN:
  - L == 0 or L > `ROM_WORDS`: set `error_o` and go to HUNT. No write occurs.
  - Otherwise latch L, set word index to 0, set `sum = L`, and go to LO.
- LO: latch the low byte, add it to `sum`, go to HI.
- HI: add the byte to `sum` and issue the write (`{byte, lo}` at the current index).
  - If index == L−1, go to CHECK. Otherwise increment the index and go to LO.
- CHECK:
  - `sum + C == 0` (8-bit wrap): go to DONE.
  - Otherwise set `error_o` and go to HUNT.
- DONE: `cpu_reset_o` = 0 and `done_o` = 1. A `SYNC_BYTE` restarts loading (go to LEN, `cpu_reset_o` = 1, `done_o` = 0). Other bytes are ignored.
- `cpu_reset_o` is 1 in every state except DONE. A failed frame leaves the PROM partially overwritten, and the CPU stays in reset.
- `busy_o` = 1 in LEN, LO, HI and CHECK.
- Timeout: a counter clears on every strobe and counts while `busy_o` is 1. When it reaches `TIMEOUT_TICKS − 1`, set `error_o` and go to HUNT.
- Arithmetic: `sum` is 8 bits and wraps. The index is AW bits and never exceeds L−1.

## Timing
- Reset values: state HUNT, `cpu_reset_o` = 1, `prom_we_o` = 0, `prom_addr_o` = 0, `prom_data_o` = 0, `busy_o`/`done_o`/`error_o` = 0.
  - Reset is asynchronous and may assert mid-frame. No write is issued after reset asserts.
- All outputs except `rx_ack_o` are registered.
- `prom_we_o` is high exactly one cycle: the cycle after the HI strobe. Address and data are valid in that same cycle.
- `done_o` rises and `cpu_reset_o` falls one cycle after the accepting strobe. That strobe is the CHECK strobe (or the last HI strobe when the macro is off).
- `error_o` rises one cycle after the offending strobe or timeout.
- Strobes on consecutive cycles are processed at full rate, with no dropped bytes.
- A strobe in the same cycle as timeout expiry counts as a byte; the timeout does not fire.

## Configuration
- `PROM_LOADER_CHECKSUM_EN` defined:
  - The CHECK state and checksum byte exist, as described above.
- `PROM_LOADER_CHECKSUM_EN` undefined:
  - The frame ends after the last payload byte. HI with index == L−1 goes directly to DONE.
  - No `sum` register is present. `error_o` is raised only for an invalid length or a timeout.

## Structure
- `prom_loader_pkg` holds:
  - the state enum typedef;
  - the default `SYNC_BYTE` constant;
  - the checksum width constant (8).
- Sub-module `prom_loader_timer`: the timeout counter, with a clear input, an enable input and an expire pulse output.

## Test plan
- Good load: A5 02 34 12 78 56 EA.
  - Writes 0x1234@0 and 0x5678@1.
  - `done_o` = 1 and `cpu_reset_o` = 0 one cycle after EA; `error_o` = 0.
- Bad checksum: the same frame ending EB.
  - Two writes occur; then `error_o` = 1, `done_o` = 0, `cpu_reset_o` = 1.
  - A following valid frame clears `error_o`.
- Length bounds:
  - L = 0x27 (39) → `error_o`, no writes.
  - L = 0x26 with a correct checksum → 38 writes, the last at address 37, then DONE.
- Noise before sync: 00 FF 5A, then the good frame.
  - The first three bytes are ignored; the result is identical to the good-load case.
- Timeout: A5 01 34, then silence.
  - `error_o` rises `TIMEOUT_TICKS` cycles after the 34 strobe; no write; `busy_o` drops.
- Async reset asserted between the LO and HI bytes of word 3, plus a back-to-back strobe stream:
  - outputs take reset values immediately;
  - no `prom_we_o` pulse follows;
  - back-to-back strobes with zero gap load correctly.
